// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, line levels and default baud parameters.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  localparam int unsigned OVERSAMPLE        = 16;
  localparam logic        START_BIT         = 1'b0;
  localparam logic        STOP_BIT          = 1'b1;
  localparam int unsigned DEFAULT_BIT_DEPTH = 11;
  localparam int unsigned DEFAULT_ADDER     = 170;

endpackage

// File: rtl/uart_baud_tick.sv
// Phase-accumulator baud generator: the carry-out of a free-running adder is a
// one-clock tick at f_clk * ADDER / 2^BIT_DEPTH (16x the baud rate).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = DEFAULT_BIT_DEPTH,
  parameter int unsigned ADDER     = DEFAULT_ADDER
) (
  input  logic clk,
  input  logic clear,
  output logic tick
);

  logic [BIT_DEPTH-1:0] acc_q;
  logic [BIT_DEPTH:0]   sum;

  always_comb begin
    sum = {1'b0, acc_q} + (BIT_DEPTH + 1)'(ADDER);
  end

  assign tick = sum[BIT_DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      acc_q <= '0;
    end else begin
      acc_q <= sum[BIT_DEPTH-1:0];
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1/8N2, LSB first, valid/ready byte input, registered TX line.
// Each bit spans OVERSAMPLE baud ticks from the shared phase-accumulator generator.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = DEFAULT_BIT_DEPTH,
  parameter int unsigned ADDER     = DEFAULT_ADDER,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_transmitter: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] OsLast   = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic [3:0]  os_cnt_q;
  logic        tx_q;
  logic        tick;
  logic        accept;
  logic        bit_end;

  assign tx_ready = (state_q == StIdle) && nrst;
  assign busy     = (state_q != StIdle) && nrst;
  assign tx       = tx_q;
  assign accept   = tx_valid && tx_ready;
  assign bit_end  = tick && (os_cnt_q == OsLast);

  // Acceptance restarts the baud phase so every frame starts on a full bit period.
  uart_baud_tick #(
    .BIT_DEPTH(BIT_DEPTH),
    .ADDER    (ADDER)
  ) u_baud_tick (
    .clk  (clk),
    .clear(accept || !nrst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      os_cnt_q  <= '0;
      tx_q      <= STOP_BIT;
    end else if (accept) begin
      state_q   <= StStart;
      shift_q   <= tx_data;
      bit_idx_q <= '0;
      os_cnt_q  <= '0;
      tx_q      <= START_BIT;
    end else if (tick) begin
      os_cnt_q <= os_cnt_q + 4'd1;
      if (bit_end) begin
        unique case (state_q)
          StIdle: begin
            state_q <= StIdle;
          end
          StStart: begin
            state_q <= StData;
            tx_q    <= shift_q[0];
          end
          StData: begin
            if (bit_idx_q == 3'd7) begin
              state_q   <= StStop;
              bit_idx_q <= '0;
              tx_q      <= STOP_BIT;
            end else begin
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end
          StStop: begin
            if (bit_idx_q == StopLast) begin
              state_q   <= StIdle;
              bit_idx_q <= '0;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
            tx_q <= STOP_BIT;
          end
          default: begin
            state_q <= StIdle;
            tx_q    <= STOP_BIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: tick every 2 clocks, so one bit = 32 clocks.
// Instance 1 uses one stop bit, instance 2 uses two stop bits.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] tx_data1, tx_data2;
  logic       tx_valid1, tx_valid2;
  logic       tx_ready1, tx_ready2;
  logic       tx1, tx2;
  logic       busy1, busy2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_transmitter #(
    .BIT_DEPTH(4),
    .ADDER    (8),
    .STOP_BITS(1)
  ) dut1 (
    .clk     (clk),
    .nrst    (nrst),
    .tx_data (tx_data1),
    .tx_valid(tx_valid1),
    .tx_ready(tx_ready1),
    .tx      (tx1),
    .busy    (busy1)
  );

  uart_transmitter #(
    .BIT_DEPTH(4),
    .ADDER    (8),
    .STOP_BITS(2)
  ) dut2 (
    .clk     (clk),
    .nrst    (nrst),
    .tx_data (tx_data2),
    .tx_valid(tx_valid2),
    .tx_ready(tx_ready2),
    .tx      (tx2),
    .busy    (busy2)
  );

  // Observation only: records each bit's level (first cycle), counts level changes
  // inside a bit and cycles with busy high. Starts right after the acceptance edge.
  task automatic capture(input bit sel, input int nbits, output logic [10:0] got,
                         output int glitches, output int busy_cycles);
    logic first, cur, bz;
    got         = '1;
    glitches    = 0;
    busy_cycles = 0;
    first       = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        cur = sel ? tx2 : tx1;
        bz  = sel ? busy2 : busy1;
        if (c == 0) first = cur;
        else if (cur !== first) glitches++;
        if (bz === 1'b1) busy_cycles++;
      end
      got[b] = first;
    end
  endtask

  task automatic test_reset();
    logic [10:0] got;
    int gl, bc;
    nrst      = 1'b0;
    tx_valid1 = 1'b1;
    tx_data1  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx1, tx_ready1, busy1} !== 3'b100)
        $display("FAIL reset_hold[%0d] tx/ready/busy=%b want=100", i, {tx1, tx_ready1, busy1});
      else n_pass++;
    end
    nrst = 1'b1;
    #1;
    n_checks++;
    if (tx_ready1 !== 1'b1) $display("FAIL reset_release_ready got=%b want=1", tx_ready1);
    else n_pass++;
    @(posedge clk);
    #1 tx_valid1 = 1'b0;
    capture(1'b0, 10, got, gl, bc);
    n_checks++;
    if (got[9:0] !== 10'b1010110100 || gl != 0)
      $display("FAIL reset_first_frame got=%b glitches=%0d want=1010110100 glitches=0",
               got[9:0], gl);
    else n_pass++;
  endtask

  task automatic test_single_byte();
    logic [10:0] got;
    int gl, bc;
    @(negedge clk);
    tx_data1  = 8'hA5;
    tx_valid1 = 1'b1;
    @(posedge clk);
    #1 tx_valid1 = 1'b0;
    capture(1'b0, 10, got, gl, bc);
    n_checks++;
    if (got[9:0] !== 10'b1101001010)
      $display("FAIL single_frame got=%b want=1101001010", got[9:0]);
    else n_pass++;
    n_checks++;
    if (gl != 0) $display("FAIL single_bit_width glitches=%0d want=0", gl);
    else n_pass++;
    n_checks++;
    if (bc != 320) $display("FAIL single_busy_len got=%0d want=320", bc);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({tx1, tx_ready1, busy1} !== 3'b110)
      $display("FAIL single_after tx/ready/busy=%b want=110", {tx1, tx_ready1, busy1});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] got;
    int gl, bc;
    @(negedge clk);
    tx_data1  = 8'h00;
    tx_valid1 = 1'b1;
    @(posedge clk);
    #1 tx_data1 = 8'hFF;
    capture(1'b0, 10, got, gl, bc);
    n_checks++;
    if (got[9:0] !== 10'b1000000000 || gl != 0)
      $display("FAIL b2b_frame1 got=%b glitches=%0d want=1000000000 glitches=0", got[9:0], gl);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({tx1, tx_ready1, busy1} !== 3'b110)
      $display("FAIL b2b_gap tx/ready/busy=%b want=110", {tx1, tx_ready1, busy1});
    else n_pass++;
    @(posedge clk);
    #1 tx_valid1 = 1'b0;
    capture(1'b0, 10, got, gl, bc);
    n_checks++;
    if (got[9:0] !== 10'b1111111110 || gl != 0 || bc != 320)
      $display("FAIL b2b_frame2 got=%b glitches=%0d busy=%0d want=1111111110 0 320",
               got[9:0], gl, bc);
    else n_pass++;
  endtask

  task automatic test_data_stability();
    logic [10:0] got;
    int gl, bc;
    @(negedge clk);
    tx_data1  = 8'hA5;
    tx_valid1 = 1'b1;
    @(posedge clk);
    #1 tx_valid1 = 1'b0;
    fork
      capture(1'b0, 10, got, gl, bc);
      begin
        repeat (2) @(posedge clk);
        #1 tx_data1 = 8'h3C;
      end
    join
    n_checks++;
    if (got[9:0] !== 10'b1101001010 || gl != 0)
      $display("FAIL stability_frame got=%b glitches=%0d want=1101001010 glitches=0",
               got[9:0], gl);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] got;
    int gl, bc;
    @(negedge clk);
    @(negedge clk);
    tx_data1  = 8'hA5;
    tx_valid1 = 1'b1;
    @(posedge clk);
    #1 tx_valid1 = 1'b0;
    repeat (140) @(negedge clk);
    n_checks++;
    if (tx1 !== 1'b0 || busy1 !== 1'b1)
      $display("FAIL midreset_before tx/busy=%b%b want=01", tx1, busy1);
    else n_pass++;
    nrst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tx1, tx_ready1, busy1} !== 3'b100)
      $display("FAIL midreset_after tx/ready/busy=%b want=100", {tx1, tx_ready1, busy1});
    else n_pass++;
    @(negedge clk);
    nrst      = 1'b1;
    tx_data1  = 8'h55;
    tx_valid1 = 1'b1;
    @(posedge clk);
    #1 tx_valid1 = 1'b0;
    capture(1'b0, 10, got, gl, bc);
    n_checks++;
    if (got[9:0] !== 10'b1010101010 || gl != 0 || bc != 320)
      $display("FAIL midreset_resend got=%b glitches=%0d busy=%0d want=1010101010 0 320",
               got[9:0], gl, bc);
    else n_pass++;
  endtask

  task automatic test_two_stop();
    logic [10:0] got;
    int gl, bc;
    @(negedge clk);
    tx_data2  = 8'hFF;
    tx_valid2 = 1'b1;
    @(posedge clk);
    #1 tx_valid2 = 1'b0;
    capture(1'b1, 11, got, gl, bc);
    n_checks++;
    if (got !== 11'b11111111110 || gl != 0)
      $display("FAIL two_stop_frame got=%b glitches=%0d want=11111111110 glitches=0", got, gl);
    else n_pass++;
    n_checks++;
    if (bc != 352) $display("FAIL two_stop_len got=%0d want=352", bc);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({tx2, tx_ready2, busy2} !== 3'b110)
      $display("FAIL two_stop_after tx/ready/busy=%b want=110", {tx2, tx_ready2, busy2});
    else n_pass++;
  endtask

  initial begin
    tx_data2  = 8'h00;
    tx_valid2 = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_data_stability();
    test_reset_mid_frame();
    test_two_stop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
